// File: rtl/add_acc_pkg.sv
// Shared types and constants for the frame accumulator.
package add_acc_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_e;

endpackage

// File: rtl/add_accumulator_cia.sv
// 32-bit carry-increment adder: 4-bit blocks add with carry-in 0, then increment on block carry.
module add_accumulator_cia (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        of
);

  localparam int unsigned BlkW = 4;
  localparam int unsigned NBlk = 8;

  logic [NBlk:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NBlk; i++) begin : g_blk
    logic [BlkW:0] s0;
    logic [BlkW:0] s1;

    assign s0 = {1'b0, a[i*BlkW +: BlkW]} + {1'b0, b[i*BlkW +: BlkW]};
    assign s1 = {1'b0, s0[BlkW-1:0]} + (BlkW+1)'(1);
    assign sum[i*BlkW +: BlkW] = c[i] ? s1[BlkW-1:0] : s0[BlkW-1:0];
    // s0 and s1 can never both carry: s0 tops out at 4'hE when its carry is set.
    assign c[i+1] = s0[BlkW] | (c[i] & s1[BlkW]);
  end

  assign cout = c[NBlk];
  assign of   = (a[31] == b[31]) && (sum[31] != a[31]);

endmodule

// File: rtl/add_accumulator.sv
// Frame accumulator: sums a valid/ready operand stream per in_last-delimited frame through one
// carry-increment adder, with optional signed saturation and an overflow event counter.
module add_accumulator
  import add_acc_pkg::*;
#(
  parameter int unsigned CNT_W  = 8,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_of_cnt,
  output logic              out_sat
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    of_cnt_q, of_cnt_d;
  logic                sat_q, sat_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_sum_q, out_sum_d;
  logic [CNT_W-1:0]    out_of_cnt_q, out_of_cnt_d;
  logic                out_sat_q, out_sat_d;

  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   add_sum;
  logic                add_of;
  logic                unused_cout;
  logic                beat;
  logic [CNT_W-1:0]    base_cnt;
  logic                base_sat;

  assign in_ready = rst_n && (state_q != HOLD);
  assign beat     = in_valid && in_ready;
  assign op_a     = (state_q == IDLE) ? '0 : acc_q;
  // The first beat of a frame starts the counters fresh.
  assign base_cnt = (state_q == IDLE) ? '0 : of_cnt_q;
  assign base_sat = (state_q == IDLE) ? 1'b0 : sat_q;

  add_accumulator_cia u_adder (
    .a    (op_a),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (unused_cout),
    .of   (add_of)
  );

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    of_cnt_d     = of_cnt_q;
    sat_d        = sat_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;
    out_of_cnt_d = out_of_cnt_q;
    out_sat_d    = out_sat_q;

    if (beat) begin
      acc_d    = add_sum;
      of_cnt_d = base_cnt;
      sat_d    = base_sat;
      if (add_of) begin
        if (!(&base_cnt)) of_cnt_d = base_cnt + CNT_W'(1);
        if (SAT_EN) begin
          acc_d = op_a[DATA_W-1] ? SAT_MIN : SAT_MAX;
          sat_d = 1'b1;
        end
      end
      if (in_last) begin
        state_d      = HOLD;
        out_valid_d  = 1'b1;
        out_sum_d    = acc_d;
        out_of_cnt_d = of_cnt_d;
        out_sat_d    = sat_d;
      end else begin
        state_d = ACC;
      end
    end

    if ((state_q == HOLD) && out_ready) begin
      state_d     = IDLE;
      acc_d       = '0;
      of_cnt_d    = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      of_cnt_q     <= '0;
      sat_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_of_cnt_q <= '0;
      out_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      of_cnt_q     <= of_cnt_d;
      sat_q        <= sat_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
      out_of_cnt_q <= out_of_cnt_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_of_cnt = out_of_cnt_q;
  assign out_sat    = out_sat_q;

endmodule

// File: tb/tb_add_accumulator.sv
// Self-checking bench: a saturating (CNT_W=8) and a wrapping (CNT_W=2) instance share one stream.
module tb_add_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;

  logic        in_ready0, out_valid0, out_sat0;
  logic [31:0] out_sum0;
  logic [7:0]  out_of_cnt0;
  logic        in_ready1, out_valid1, out_sat1;
  logic [31:0] out_sum1;
  logic [1:0]  out_of_cnt1;

  typedef struct {
    logic [31:0] sum;
    logic [7:0]  cnt;
    logic        sat;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  exp_t        e0, e1;
  logic [31:0] frame_q[$];
  int          errors = 0;
  int          checks = 0;

  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -64'sh8000_0000;

  add_accumulator #(.CNT_W(8), .SAT_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready0),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid0),
    .out_ready  (out_ready),
    .out_sum    (out_sum0),
    .out_of_cnt (out_of_cnt0),
    .out_sat    (out_sat0)
  );

  add_accumulator #(.CNT_W(2), .SAT_EN(1'b0)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready1),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid1),
    .out_ready  (out_ready),
    .out_sum    (out_sum1),
    .out_of_cnt (out_of_cnt1),
    .out_sat    (out_sat1)
  );

  // Reference: exact 64-bit signed sum, then clamp or wrap back to 32 bits on overflow.
  function automatic exp_t model(input bit sat_en, input int cnt_w);
    exp_t   e;
    longint acc;
    longint s;
    int     cmax;
    int     cnt;
    acc   = 0;
    cnt   = 0;
    cmax  = (1 << cnt_w) - 1;
    e.sat = 1'b0;
    foreach (frame_q[i]) begin
      s = acc + longint'($signed(frame_q[i]));
      if (s > SMAX || s < SMIN) begin
        if (cnt < cmax) cnt++;
        if (sat_en) begin
          acc   = (s > 0) ? SMAX : SMIN;
          e.sat = 1'b1;
        end else begin
          acc = longint'($signed(s[31:0]));
        end
      end else begin
        acc = s;
      end
    end
    e.sum = acc[31:0];
    e.cnt = cnt[7:0];
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      checks++;
      if (sb0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected got sum=%h cnt=%0d sat=%0d", out_sum0, out_of_cnt0, out_sat0);
      end else begin
        e0 = sb0.pop_front();
        if (out_sum0 !== e0.sum || out_of_cnt0 !== e0.cnt || out_sat0 !== e0.sat) begin
          errors++;
          $display("FAIL sb0_result got sum=%h cnt=%0d sat=%0d want sum=%h cnt=%0d sat=%0d",
                   out_sum0, out_of_cnt0, out_sat0, e0.sum, e0.cnt, e0.sat);
        end
      end
    end
    if (rst_n && out_valid1 && out_ready) begin
      checks++;
      if (sb1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected got sum=%h cnt=%0d sat=%0d", out_sum1, out_of_cnt1, out_sat1);
      end else begin
        e1 = sb1.pop_front();
        if (out_sum1 !== e1.sum || {6'b0, out_of_cnt1} !== e1.cnt || out_sat1 !== e1.sat) begin
          errors++;
          $display("FAIL sb1_result got sum=%h cnt=%0d sat=%0d want sum=%h cnt=%0d sat=%0d",
                   out_sum1, out_of_cnt1, out_sat1, e1.sum, e1.cnt, e1.sat);
        end
      end
    end
  end

  task automatic push_expected();
    sb0.push_back(model(1'b1, 8));
    sb1.push_back(model(1'b0, 2));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready0) begin
      errors++;
      $display("FAIL in_ready_timeout got in_ready=%0b want 1", in_ready0);
      $fatal(1, "in_ready never rose");
    end
  endtask

  task automatic send_frame(input bit do_push, input bit use_last);
    if (do_push) push_expected();
    foreach (frame_q[i]) begin
      in_valid = 1'b1;
      in_data  = frame_q[i];
      in_last  = use_last && (i == frame_q.size() - 1);
      wait_ready();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || out_sum0 !== 32'h0 ||
        out_of_cnt0 !== 8'h0 || out_sat0 !== 1'b0 || out_valid1 !== 1'b0 ||
        out_of_cnt1 !== 2'h0) begin
      errors++;
      $display("FAIL reset_state got rdy=%0b vld=%0b sum=%h cnt=%0d sat=%0b want all 0",
               in_ready0, out_valid0, out_sum0, out_of_cnt0, out_sat0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %0b want 1", in_ready0);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    frame_q = '{32'h10, 32'h20, 32'h30};
    send_frame(1'b1, 1'b1);
    checks++;
    if (out_valid0 !== 1'b1 || out_sum0 !== 32'h60 || out_of_cnt0 !== 8'd0 || out_sat0 !== 1'b0)
    begin
      errors++;
      $display("FAIL basic_sum got vld=%0b sum=%h cnt=%0d sat=%0b want 1 00000060 0 0",
               out_valid0, out_sum0, out_of_cnt0, out_sat0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid0 !== 1'b0) begin
      errors++;
      $display("FAIL basic_valid_pulse got %0b want 0", out_valid0);
    end
  endtask

  task automatic test_overflow();
    frame_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
    send_frame(1'b1, 1'b1);
    checks++;
    if (out_sum0 !== 32'h7FFF_FFFF || out_of_cnt0 !== 8'd1 || out_sat0 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sat got sum=%h cnt=%0d sat=%0b want 7fffffff 1 1",
               out_sum0, out_of_cnt0, out_sat0);
    end
    checks++;
    if (out_sum1 !== 32'hFFFF_FFFE || out_of_cnt1 !== 2'd1 || out_sat1 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_wrap got sum=%h cnt=%0d sat=%0b want fffffffe 1 0",
               out_sum1, out_of_cnt1, out_sat1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_clamp_continue();
    frame_q = '{32'h8FFF_FFFF, 32'h8FFF_FFFF, 32'h5};
    send_frame(1'b1, 1'b1);
    checks++;
    if (out_sum0 !== 32'h8000_0005 || out_of_cnt0 !== 8'd1 || out_sat0 !== 1'b1) begin
      errors++;
      $display("FAIL clamp_continue got sum=%h cnt=%0d sat=%0b want 80000005 1 1",
               out_sum0, out_of_cnt0, out_sat0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    frame_q = '{32'h7AA, 32'hFFFF_FFFF};
    send_frame(1'b1, 1'b1);
    frame_q = '{32'h100};
    push_expected();
    in_valid = 1'b1;
    in_data  = 32'h100;
    in_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || out_sum0 !== 32'h7A9) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%0b vld=%0b sum=%h want 0 1 000007a9",
                 k, in_ready0, out_valid0, out_sum0);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld=%0b rdy=%0b want 0 1", out_valid0, in_ready0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (out_valid0 !== 1'b1 || out_sum0 !== 32'h100) begin
      errors++;
      $display("FAIL bp_next_frame got vld=%0b sum=%h want 1 00000100", out_valid0, out_sum0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    frame_q = '{32'h123, 32'hFFFF_F123};
    send_frame(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0 || out_sum0 !== 32'h0 ||
        out_of_cnt0 !== 8'h0 || out_sat0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got rdy=%0b vld=%0b sum=%h cnt=%0d sat=%0b want all 0",
               in_ready0, out_valid0, out_sum0, out_of_cnt0, out_sat0);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready got %0b want 0", in_ready0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame_q = '{32'h0, 32'hFFFF_FFFF};
    send_frame(1'b1, 1'b1);
    checks++;
    if (out_sum0 !== 32'hFFFF_FFFF || out_of_cnt0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_frame got sum=%h cnt=%0d want ffffffff 0", out_sum0, out_of_cnt0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cnt_sat();
    frame_q.delete();
    // Wrapping alternates overflow/no-overflow, so 11 beats give 5 overflow events.
    for (int k = 0; k < 11; k++) frame_q.push_back(32'h7FFF_FFFF);
    send_frame(1'b1, 1'b1);
    checks++;
    if (out_of_cnt1 !== 2'd3) begin
      errors++;
      $display("FAIL cnt_sat got %0d want 3", out_of_cnt1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      frame_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 5)); k++) frame_q.push_back($urandom());
      send_frame(1'b1, 1'b1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL drain got pending=%0d/%0d want 0/0", sb0.size(), sb1.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_clamp_continue();
    test_backpressure();
    test_reset_mid();
    test_cnt_sat();
    test_back_to_back();
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_accumulator.md
Name: add_accumulator

Overview:
Stream consumer of the team's 32-bit carry-increment adder. It accepts a valid/ready stream of signed 32-bit operands grouped into frames by in_last, and accumulates each frame into a running sum through one adder instance. Signed overflow is optionally saturated, and overflow events are counted. One result per frame is presented on a valid/ready output port.

Parameters:
CNT_W, 8, width of the per-frame overflow event counter.
SAT_EN, 1, 1 = clamp the accumulator on signed overflow; 0 = two's-complement wrap.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept a beat.
in_data  in  32  signed operand.
in_last  in  1  final beat of the frame; qualified by in_valid.
out_valid  out  1  frame result valid.
out_ready  in  1  downstream accepts the result.
out_sum  out  32  signed frame sum.
out_of_cnt  out  CNT_W  number of overflow events in the frame; saturates at all-ones.
out_sat  out  1  sticky flag: at least one clamp occurred in the frame (always 0 when SAT_EN=0).

Behaviour:
- States: IDLE (no frame open), ACC (frame open), HOLD (result presented).
- Reset (rst_n low, asynchronous): state=IDLE; acc, of_cnt, sat=0; out_valid=0; out_sum=0; out_of_cnt=0; out_sat=0. in_ready is forced 0 while rst_n is low.
- in_ready = (state != HOLD) when not in reset. A beat is accepted when in_valid && in_ready.
- Adder hookup: a = (state==IDLE ? 0 : acc), b = in_data, Cin = 0. sum, Cout and of are taken combinationally in the same cycle.
- On an accepted beat:
  - of=0: next acc = sum.
  - of=1 and SAT_EN=1: next acc = 0x7FFFFFFF if a[31]==0, else 0x80000000; sat is set.
  - of=1 and SAT_EN=0: next acc = sum.
  - of=1, any SAT_EN: of_cnt increments unless it is already all-ones.
  - Cout is ignored.
  - On the first beat of a frame (IDLE), of_cnt and sat are loaded fresh rather than accumulated.
- Transitions:
  - IDLE: accepted beat without last -> ACC; accepted beat with last -> HOLD.
  - ACC: accepted beat with last -> HOLD.
  - HOLD: out_ready high -> IDLE. acc, of_cnt and sat clear in the same edge.
- Latency: out_valid rises on the edge that accepts the last beat, so the result is visible the cycle after the last beat is on the bus.
- out_sum, out_of_cnt and out_sat are registered. They are stable while out_valid && !out_ready.
- out_valid falls on the edge where out_ready is sampled high in HOLD. Earliest next beat acceptance is the following cycle, giving one bubble per frame.
- The block never drops or duplicates a beat under any in_valid/out_ready pattern.
- Accumulation continues from a clamped value; a later beat can move the sum back inside range.
- A single-beat frame (in_last on the first beat) is legal: result = in_data, no overflow is possible.

Decomposition:
- Package add_acc_pkg holds:
  - state enum {IDLE, ACC, HOLD};
  - SAT_MAX = 32'h7FFFFFFF;
  - SAT_MIN = 32'h80000000;
  - DATA_W = 32.
- Sub-module: one instance of the existing 32-bit carry-increment adder, unchanged. No new sub-module.
- FSM, saturation mux and counters live in add_accumulator.

Test Plan:
1. Frame 0x10, 0x20, 0x30 (last on 0x30), out_ready=1 -> out_sum=0x00000060, out_of_cnt=0, out_sat=0; out_valid high exactly 1 cycle, asserted the cycle after the last beat.
2. SAT_EN=1, frame 0x7FFFFFFF, 0x7FFFFFFF(last) -> out_sum=0x7FFFFFFF, out_of_cnt=1, out_sat=1. Same frame with SAT_EN=0 -> out_sum=0xFFFFFFFE, out_of_cnt=1, out_sat=0.
3. SAT_EN=1, frame 0x8FFFFFFF, 0x8FFFFFFF, 0x00000005(last) -> out_sum=0x80000005, out_of_cnt=1, out_sat=1 (accumulation continues after the clamp).
4. Backpressure: result of frame 0x7AA, 0xFFFFFFFF(last); out_ready low 5 cycles with in_valid held high -> in_ready=0, out_sum=0x000007A9 stable throughout. Then out_ready=1 -> IDLE, the next frame's first beat is accepted the following cycle, and its sum excludes 0x7A9.
5. Reset mid-frame: accept 0x123, 0xFFFFF123, then pull rst_n low for 2 cycles -> all outputs 0 immediately, in_ready=0 during reset. After release, frame 0x0, 0xFFFFFFFF(last) -> out_sum=0xFFFFFFFF, out_of_cnt=0.
6. Counter saturation: CNT_W=2, 5 successive overflowing beats of 0x7FFFFFFF with SAT_EN=0, then last -> out_of_cnt=3 (held at all-ones).
